// File: rtl/cm_nest_cnt.sv
// Multi-level nested loop counter: level 0 is innermost, each level carries into the next.
// Per-level wrap flags, end-of-sweep pulse, bounds latched at start, optional stop-at-end.
module cm_nest_cnt #(
  parameter int C_WIDTH  = 8,
  parameter int C_LEVELS = 3,
  parameter int C_WRAP   = 1
) (
  input  logic                          I_clk,
  input  logic                          I_rst_n,
  input  logic                          I_cnt_en,
  input  logic                          I_cnt_valid,
  input  logic [C_LEVELS*C_WIDTH-1:0]   I_cnt_upper,
  output logic [C_LEVELS*C_WIDTH-1:0]   O_cnt,
  output logic [C_LEVELS-1:0]           O_last,
  output logic                          O_done,
  output logic                          O_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [C_LEVELS*C_WIDTH-1:0]   cnt_q, cnt_d;
  logic [C_LEVELS*C_WIDTH-1:0]   upper_q, upper_d;
  logic [C_LEVELS-1:0]           last_q, last_d;
  logic                          done_q, done_d;
  logic                          busy_q, busy_d;

  // A zero bound behaves like a bound of one: the only index is 0.
  function automatic logic [C_WIDTH-1:0] fin_of(input logic [C_WIDTH-1:0] u);
    return (u == '0) ? '0 : u - 1'b1;
  endfunction

  always_comb begin
    logic adv;
    logic chain;
    state_d = state_q;
    cnt_d   = cnt_q;
    upper_d = upper_q;
    done_d  = 1'b0;
    adv     = 1'b1;
    chain   = 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (I_cnt_en) begin
          state_d = S_RUN;
          upper_d = I_cnt_upper;
        end
      end
      S_RUN: begin
        if (!I_cnt_en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (I_cnt_valid) begin
          if (last_q[C_LEVELS-1]) begin
            done_d = 1'b1;
            if (C_WRAP == 0) state_d = S_HOLD;
          end
          // In stop mode the final tuple is kept rather than wrapped.
          if (!last_q[C_LEVELS-1] || (C_WRAP != 0)) begin
            for (int unsigned i = 0; i < C_LEVELS; i++) begin
              if (adv) begin
                if (cnt_q[i*C_WIDTH +: C_WIDTH] == fin_of(upper_q[i*C_WIDTH +: C_WIDTH]))
                  cnt_d[i*C_WIDTH +: C_WIDTH] = '0;
                else
                  cnt_d[i*C_WIDTH +: C_WIDTH] = cnt_q[i*C_WIDTH +: C_WIDTH] + 1'b1;
              end
              adv = last_q[i];
            end
          end
        end
      end
      S_HOLD: begin
        if (!I_cnt_en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Flags come from the next-state counts so they line up with O_cnt.
    for (int unsigned i = 0; i < C_LEVELS; i++) begin
      chain = chain &
              (cnt_d[i*C_WIDTH +: C_WIDTH] == fin_of(upper_d[i*C_WIDTH +: C_WIDTH]));
      last_d[i] = chain;
    end
    if (state_d == S_IDLE) last_d = '0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      upper_q <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      upper_q <= upper_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign O_cnt  = cnt_q;
  assign O_last = last_q;
  assign O_done = done_q;
  assign O_busy = busy_q;

endmodule

// File: tb/tb_cm_nest_cnt.sv
// Self-checking bench for cm_nest_cnt: three configurations checked against a
// linear-index (mixed-radix) reference model of the nested sweep.
module tb_cm_nest_cnt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_en = 1'b0;
  logic        cnt_valid = 1'b0;
  logic [7:0]  m_in_up [3] = '{8'd0, 8'd0, 8'd0};

  logic [23:0] upper_a;
  logic [7:0]  upper_w;
  logic [23:0] cnt_a, cnt_h;
  logic [7:0]  cnt_w;
  logic [2:0]  last_a, last_h;
  logic [1:0]  last_w;
  logic        done_a, done_h, done_w, busy_a, busy_h, busy_w;

  always #5 clk = ~clk;

  assign upper_a = {m_in_up[2], m_in_up[1], m_in_up[0]};
  assign upper_w = {m_in_up[1][3:0], m_in_up[0][3:0]};

  cm_nest_cnt #(.C_WIDTH(8), .C_LEVELS(3), .C_WRAP(1)) dut_a (
    .I_clk(clk), .I_rst_n(rst_n), .I_cnt_en(cnt_en), .I_cnt_valid(cnt_valid),
    .I_cnt_upper(upper_a), .O_cnt(cnt_a), .O_last(last_a), .O_done(done_a), .O_busy(busy_a));

  cm_nest_cnt #(.C_WIDTH(8), .C_LEVELS(3), .C_WRAP(0)) dut_h (
    .I_clk(clk), .I_rst_n(rst_n), .I_cnt_en(cnt_en), .I_cnt_valid(cnt_valid),
    .I_cnt_upper(upper_a), .O_cnt(cnt_h), .O_last(last_h), .O_done(done_h), .O_busy(busy_h));

  cm_nest_cnt #(.C_WIDTH(4), .C_LEVELS(2), .C_WRAP(1)) dut_w (
    .I_clk(clk), .I_rst_n(rst_n), .I_cnt_en(cnt_en), .I_cnt_valid(cnt_valid),
    .I_cnt_upper(upper_w), .O_cnt(cnt_w), .O_last(last_w), .O_done(done_w), .O_busy(busy_w));

  // Which DUT is under test, with its outputs normalised to 8-bit lanes.
  int          sel = 0;
  logic [23:0] obs_cnt;
  logic [2:0]  obs_last;
  logic        obs_done, obs_busy;

  always_comb begin
    obs_cnt = cnt_a; obs_last = last_a; obs_done = done_a; obs_busy = busy_a;
    if (sel == 1) begin
      obs_cnt = cnt_h; obs_last = last_h; obs_done = done_h; obs_busy = busy_h;
    end else if (sel == 2) begin
      obs_cnt  = {8'd0, 4'd0, cnt_w[7:4], 4'd0, cnt_w[3:0]};
      obs_last = {1'b0, last_w};
      obs_done = done_w; obs_busy = busy_w;
    end
  end

  // Reference model: the sweep is one linear index; lanes are its mixed-radix digits.
  int     n_tests = 0;
  int     n_fail  = 0;
  int     ms      = 0;      // 0 idle, 1 running, 2 holding at the end
  longint m_idx   = 0;
  longint m_ub [3] = '{1, 1, 1};
  logic   m_done  = 1'b0;
  int     m_lv    = 3;
  bit     m_wrap  = 1'b1;

  function automatic longint prod(input int n);
    longint p = 1;
    for (int j = 0; j < n; j++) p = p * m_ub[j];
    return p;
  endfunction

  function automatic logic [23:0] exp_cnt();
    logic [23:0] r = '0;
    longint d;
    if (ms == 0) return r;
    for (int i = 0; i < m_lv; i++) begin
      d = (m_idx / prod(i)) % m_ub[i];
      r[i*8 +: 8] = d[7:0];
    end
    return r;
  endfunction

  function automatic logic [2:0] exp_last();
    logic [2:0] r = '0;
    longint p;
    if (ms == 0) return r;
    for (int i = 0; i < m_lv; i++) begin
      p = prod(i + 1);
      r[i] = ((m_idx % p) == p - 1);
    end
    return r;
  endfunction

  task automatic tick(input logic rn, input logic en, input logic v);
    rst_n = rn; cnt_en = en; cnt_valid = v;
    if (!rn) begin
      ms = 0; m_idx = 0; m_done = 1'b0;
    end else if (ms == 0) begin
      m_done = 1'b0;
      if (en) begin
        ms = 1; m_idx = 0;
        for (int j = 0; j < 3; j++)
          m_ub[j] = (j < m_lv) ? ((m_in_up[j] == 0) ? 1 : longint'(m_in_up[j])) : 1;
      end
    end else if (!en) begin
      ms = 0; m_idx = 0; m_done = 1'b0;
    end else if (ms == 2) begin
      m_done = 1'b0;
    end else if (v) begin
      if (m_idx == prod(m_lv) - 1) begin
        m_done = 1'b1;
        if (m_wrap) m_idx = 0;
        else ms = 2;
      end else begin
        m_idx++; m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic setup(input int s, input int u0, input int u1, input int u2);
    sel = s; m_lv = (s == 2) ? 2 : 3; m_wrap = (s != 1);
    m_in_up[0] = 8'(u0); m_in_up[1] = 8'(u1); m_in_up[2] = 8'(u2);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    setup(0, 4, 3, 2);
    tick(1'b0, 1'b1, 1'b1);
    if (obs_cnt !== 24'd0 || obs_last !== 3'd0 || obs_done !== 1'b0 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: cnt=%h last=%b done=%b busy=%b, want all 0", obs_cnt, obs_last, obs_done, obs_busy);
    end
    n_tests++;
  endtask

  task automatic test_reset_mid();
    setup(0, 4, 3, 2);
    tick(1'b1, 1'b1, 1'b0);
    repeat (5) tick(1'b1, 1'b1, 1'b1);
    if (obs_cnt !== 24'h000101) begin
      n_fail++; $display("FAIL reset_mid_pos: cnt=%h want 000101", obs_cnt);
    end
    n_tests++;
    tick(1'b0, 1'b1, 1'b1);
    if (obs_cnt !== 24'd0 || obs_last !== 3'd0 || obs_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: cnt=%h last=%b busy=%b, want 0", obs_cnt, obs_last, obs_busy);
    end
    n_tests++;
    tick(1'b1, 1'b1, 1'b1);
    repeat (3) begin
      tick(1'b1, 1'b1, 1'b1);
      if (obs_cnt !== exp_cnt() || obs_last !== exp_last() || obs_done !== m_done || obs_busy !== (ms != 0)) begin
        n_fail++;
        $display("FAIL reenable: cnt=%h/%h last=%b/%b done=%b/%b", obs_cnt, exp_cnt(), obs_last, exp_last(), obs_done, m_done);
      end
      n_tests++;
    end
  endtask

  task automatic test_full_sweep();
    int ndone = 0;
    setup(0, 4, 3, 2);
    tick(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 30; k++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (k < 24 && obs_done) ndone++;
      if (obs_cnt !== exp_cnt() || obs_last !== exp_last() || obs_done !== m_done || obs_busy !== (ms != 0)) begin
        n_fail++;
        $display("FAIL full_sweep: adv=%0d cnt=%h/%h last=%b/%b done=%b/%b busy=%b", k + 1,
                 obs_cnt, exp_cnt(), obs_last, exp_last(), obs_done, m_done, obs_busy);
      end
      n_tests++;
    end
    if (ndone != 1) begin
      n_fail++; $display("FAIL sweep_done_count: got %0d pulses want 1", ndone);
    end
    n_tests++;
  endtask

  task automatic test_gaps_early_stop();
    int k = 0;
    logic [3:0] pat = 4'b1001;
    setup(0, 4, 3, 2);
    tick(1'b1, 1'b1, 1'b0);
    while (m_idx != 21 && k < 200) begin
      tick(1'b1, 1'b1, pat[k % 4]);
      if (obs_cnt !== exp_cnt() || obs_last !== exp_last() || obs_done !== m_done) begin
        n_fail++;
        $display("FAIL gaps: cnt=%h/%h last=%b/%b done=%b/%b", obs_cnt, exp_cnt(), obs_last, exp_last(), obs_done, m_done);
      end
      n_tests++;
      k++;
    end
    if (obs_cnt !== 24'h010201) begin
      n_fail++; $display("FAIL gaps_reach: cnt=%h want 010201", obs_cnt);
    end
    n_tests++;
    tick(1'b1, 1'b0, 1'b1);
    if (obs_cnt !== 24'd0 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_last !== 3'd0) begin
      n_fail++; $display("FAIL early_stop: cnt=%h busy=%b done=%b last=%b want idle", obs_cnt, obs_busy, obs_done, obs_last);
    end
    n_tests++;
  endtask

  task automatic test_degenerate();
    setup(0, 0, 1, 3);
    tick(1'b1, 1'b1, 1'b1);
    if (obs_last !== 3'b011 || obs_cnt !== 24'd0) begin
      n_fail++; $display("FAIL degenerate_start: last=%b want 011 cnt=%h", obs_last, obs_cnt);
    end
    n_tests++;
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (obs_cnt !== exp_cnt() || obs_last !== exp_last() || obs_done !== m_done) begin
        n_fail++;
        $display("FAIL degenerate: adv=%0d cnt=%h/%h last=%b/%b done=%b/%b", k + 1,
                 obs_cnt, exp_cnt(), obs_last, exp_last(), obs_done, m_done);
      end
      n_tests++;
    end
  endtask

  task automatic test_stop_mode();
    int ndone = 0;
    setup(1, 2, 2, 2);
    tick(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (obs_done) ndone++;
      if (obs_cnt !== exp_cnt() || obs_last !== exp_last() || obs_done !== m_done || obs_busy !== (ms != 0)) begin
        n_fail++;
        $display("FAIL stop_mode: adv=%0d cnt=%h/%h last=%b/%b done=%b/%b busy=%b", k + 1,
                 obs_cnt, exp_cnt(), obs_last, exp_last(), obs_done, m_done, obs_busy);
      end
      n_tests++;
    end
    if (ndone != 1 || obs_cnt !== 24'h010101) begin
      n_fail++; $display("FAIL stop_hold: done pulses %0d want 1, cnt=%h want 010101", ndone, obs_cnt);
    end
    n_tests++;
    tick(1'b1, 1'b0, 1'b0);
    if (obs_busy !== 1'b0 || obs_cnt !== 24'd0) begin
      n_fail++; $display("FAIL stop_exit: busy=%b cnt=%h want idle", obs_busy, obs_cnt);
    end
    n_tests++;
  endtask

  task automatic test_bound_latch();
    int ndone = 0;
    int at = 0;
    setup(0, 2, 3, 1);
    tick(1'b1, 1'b1, 1'b0);
    m_in_up[0] = 8'd7; m_in_up[1] = 8'd1; m_in_up[2] = 8'd5;
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (obs_done) begin ndone++; at = k; end
    end
    if (ndone != 1 || at != 6) begin
      n_fail++; $display("FAIL bound_latch: %0d done pulses at advance %0d, want 1 at 6", ndone, at);
    end
    n_tests++;
  endtask

  task automatic test_max_width();
    bit saw15 = 1'b0;
    setup(2, 15, $urandom_range(1, 3), 0);
    tick(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 50; k++) begin
      tick(1'b1, 1'b1, ($urandom_range(0, 7) != 0));
      if (cnt_w[3:0] == 4'hf) saw15 = 1'b1;
      if (obs_cnt !== exp_cnt() || obs_last !== exp_last() || obs_done !== m_done || obs_busy !== (ms != 0)) begin
        n_fail++;
        $display("FAIL max_width: cnt=%h/%h last=%b/%b done=%b/%b", obs_cnt, exp_cnt(), obs_last, exp_last(), obs_done, m_done);
      end
      n_tests++;
    end
    if (saw15) begin
      n_fail++; $display("FAIL max_width_15: level 0 reached 15, want max 14");
    end
    n_tests++;
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      setup(s, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(0, 15) == 0)
          for (int j = 0; j < 3; j++) m_in_up[j] = 8'($urandom_range(0, 4));
        tick(1'b1, ($urandom_range(0, 19) != 0), $urandom_range(0, 1) == 1);
        if (obs_cnt !== exp_cnt() || obs_last !== exp_last() || obs_done !== m_done || obs_busy !== (ms != 0)) begin
          n_fail++;
          $display("FAIL random(sel=%0d): cnt=%h/%h last=%b/%b done=%b/%b busy=%b", s,
                   obs_cnt, exp_cnt(), obs_last, exp_last(), obs_done, m_done, obs_busy);
        end
        n_tests++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_full_sweep();
    test_gaps_early_stop();
    test_degenerate();
    test_stop_mode();
    test_bound_latch();
    test_max_width();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cm_nest_cnt.md
Name: cm_nest_cnt

Overview:
- Parametrised multi-level nested loop counter, successor to the single-level enable/valid counter.
- Generates CNN loop indices (e.g. kx, ky, ci, co tiles) for address generators in the ibuf/wbuf/obuf paths.
- Provides per-level wrap flags with a correct carry chain, an end-of-sweep pulse, latched bounds, and optional stop-at-end mode.

Parameters:
- C_WIDTH, 8, bit width of each level's count and upper bound.
- C_LEVELS, 3, number of nested levels; level 0 is innermost (fastest).
- C_WRAP, 1, 1 = after final iteration wrap all levels to 0 and continue; 0 = stop at final value and hold until I_cnt_en drops.

Ports:
- I_clk  in  1  clock, all logic on rising edge.
- I_rst_n  in  1  synchronous reset, active low.
- I_cnt_en  in  1  run enable; low forces idle and clears counts.
- I_cnt_valid  in  1  advance request; counts only while running.
- I_cnt_upper  in  C_LEVELS*C_WIDTH  per-level iteration count; level i at bits [i*C_WIDTH +: C_WIDTH]; sampled at start.
- O_cnt  out  C_LEVELS*C_WIDTH  current index per level, same packing.
- O_last  out  C_LEVELS  O_last[i]=1 when levels 0..i all hold their final value (upper-1), i.e. the next advance carries out of level i.
- O_done  out  1  one-cycle pulse on the advance that leaves the final index tuple.
- O_busy  out  1  1 while in RUN.

Behaviour:
- Reset (I_rst_n=0 at a clock edge): state IDLE; O_cnt=0, O_last=0, O_done=0, O_busy=0; latched bounds=0. Reset has priority over everything, including mid-sweep.
- States:
  - IDLE: O_cnt=0, O_busy=0. I_cnt_en=1 -> RUN next cycle; I_cnt_upper latched on that same edge. I_cnt_valid is ignored on the entry cycle.
  - RUN: O_busy=1. I_cnt_en=0 -> IDLE next cycle, counts cleared to 0, no O_done.
  - HOLD (only when C_WRAP=0): entered on the final advance; O_cnt stays 0..0 wrapped? No: O_cnt holds upper-1 on every level, O_busy=1, I_cnt_valid is ignored. I_cnt_en=0 -> IDLE.
- Latched bound of 0 on any level is treated as 1: that level is always 0 and always final.
- Advance (RUN with I_cnt_valid=1), evaluated on registered values with 1-cycle latency:
  - level 0 increments, or wraps to 0 if final;
  - level i>0 increments/wraps only when O_last[i-1]=1, otherwise holds.
- I_cnt_valid=0 in RUN: all counts hold.
- O_last must be exact for the current O_cnt in the same cycle. It is registered from the next-state values, not delayed one cycle behind the count.
  - Upper=1 levels yield O_last[i]=O_last[i-1] immediately after start.
  - O_last is 0 in IDLE.
- O_done:
  - asserts in the cycle after the advance taken while O_last[C_LEVELS-1]=1;
  - C_WRAP=1: O_cnt becomes all 0 in that same cycle;
  - C_WRAP=0: state becomes HOLD and O_cnt holds the final values.
- Width rules:
  - final compare uses the latched upper minus 1 at C_WIDTH bits;
  - upper=2^C_WIDTH-1 is the maximum count (0..2^C_WIDTH-2); no overflow path exists.
- Changes to I_cnt_upper during RUN have no effect until the next IDLE->RUN transition.
- I_cnt_en and I_cnt_valid both high on the entry cycle: enter RUN only, no advance.

Test Plan:
- Reset mid-sweep:
  - C_LEVELS=3, upper={2,3,4} (L2,L1,L0); advance 5 times, then I_rst_n=0 for 1 cycle -> O_cnt=0, O_busy=0, O_last=0 next cycle.
  - Re-enable and advance from 0.
- Full sweep, C_WRAP=1, upper L0=4, L1=3, L2=2, valid held high:
  - 24 advances visit all tuples in L0-fastest order;
  - O_last[0] is high every 4th count;
  - O_done pulses exactly once, on the cycle O_cnt returns to 0,0,0;
  - counting then continues.
- Gaps and early stop: valid toggled 1,0,0,1 -> counts hold on 0-cycles; dropping I_cnt_en at O_cnt=(1,2,1) -> IDLE, counts 0, no O_done.
- Degenerate bounds:
  - upper L0=0, L1=1, L2=3 -> L0 and L1 stay 0 with O_last[1:0]=2'b11 from the first RUN cycle;
  - L2 counts 0,1,2; O_done after 3 advances.
- C_WRAP=0 stop: upper all 2, 8 advances -> O_done once, O_cnt holds (1,1,1); further valid is ignored; en low -> IDLE.
- Bound latching and max width:
  - change I_cnt_upper mid-RUN -> sweep length unchanged;
  - C_WIDTH=4, upper L0=15 -> L0 reaches 14 then wraps; no value 15 appears.
